// File: rtl/data_mem_multicore_pkg.sv
// Shared definitions for the multi-core data memory: default geometry,
// bank select encoding and a width helper for the round-robin pointer.
package dmem_pkg;

    localparam int NCORES_DEF = 2;
    localparam int LMEM_DEF   = 8;
    localparam int TAM_DEF    = 16;

    // Address bit LMEM picks the bank.
    typedef enum logic {
        BANK_PRIVATE = 1'b0,
        BANK_SHARED  = 1'b1
    } bank_sel_e;

    // Bits needed to index 'value' entries; never below 1 so that a
    // single-core build still gets a legal vector width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/data_mem_multicore_if.sv
// Core-side bus of the multi-core data memory. Each vector carries all
// cores side by side; core k occupies slice [k*TAM +: TAM] (or bit k).
interface data_mem_multicore_if
    import dmem_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int TAM    = TAM_DEF
) ();

    logic [NCORES*TAM-1:0] core_addr;
    logic [NCORES*TAM-1:0] core_wdata;
    logic [NCORES-1:0]     core_we;
    logic [NCORES-1:0]     core_re;
    logic [NCORES-1:0]     core_ready;
    logic [NCORES*TAM-1:0] core_rdata;
    logic [NCORES-1:0]     core_rvalid;

    // Load/store stages drive requests.
    modport master (
        output core_addr, core_wdata, core_we, core_re,
        input  core_ready, core_rdata, core_rvalid
    );

    // The memory answers them.
    modport slave (
        input  core_addr, core_wdata, core_we, core_re,
        output core_ready, core_rdata, core_rvalid
    );

endinterface

// File: rtl/data_mem_multicore_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, searching upward from
// a pointer that moves just past the winner on every grant. No grant is
// issued while rst is high.
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int N = NCORES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two passes: requesters at or above the pointer first, then wrap around.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                if (!found && req[c] && (c >= int'(ptr_q))) begin
                    gnt[c] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = PW'((c + 1) % N);
                end
            end
            for (int c = 0; c < N; c++) begin
                if (!found && req[c] && (c < int'(ptr_q))) begin
                    gnt[c] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = PW'((c + 1) % N);
                end
            end
        end
    end

    // Pointer advances only when someone is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (|gnt) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_mem_multicore.sv
// Multi-core data memory: one private bank per core plus one single-port
// shared bank granted round-robin. Reads return one cycle after acceptance.
// Optional build macro DMEM_CONFLICT_CNT_EN adds a saturating counter of
// cycles in which a shared request was refused.
module data_mem_multicore
    import dmem_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int LMEM   = LMEM_DEF,
    parameter int TAM    = TAM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_multicore_if.slave   bus
`ifdef DMEM_CONFLICT_CNT_EN
    ,
    output logic [15:0]           conflict_cnt
`endif
);

    localparam int DEPTH = 1 << LMEM;
    localparam int WW    = clog2(NCORES);

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] sh_req;
    logic [NCORES-1:0] priv_req;
    logic [NCORES-1:0] gnt;
    logic [NCORES-1:0] acc;
    logic [LMEM-1:0]   idx   [NCORES];
    logic [TAM-1:0]    wdata [NCORES];

    logic [WW-1:0]     sh_win;
    logic [LMEM-1:0]   sh_idx;
    logic [TAM-1:0]    sh_wdata;
    logic              sh_we;

    logic [TAM-1:0]    sh_mem_q [DEPTH];

    genvar gi;

    // Per-core address decode: bank select, word index, request type.
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_dec
            logic [TAM-1:0] addr;
            bank_sel_e      sel;

            assign addr         = bus.core_addr[gi*TAM +: TAM];
            assign sel          = bank_sel_e'(addr[LMEM]);
            assign idx[gi]      = addr[LMEM-1:0];
            assign wdata[gi]    = bus.core_wdata[gi*TAM +: TAM];
            assign req[gi]      = bus.core_we[gi] | bus.core_re[gi];
            assign sh_req[gi]   = req[gi] & (sel == BANK_SHARED);
            assign priv_req[gi] = req[gi] & (sel == BANK_PRIVATE);

            // Upper address bits carry no meaning for this memory.
            if (TAM > LMEM + 1) begin : g_hi
                logic unused_hi;
                assign unused_hi = ^addr[TAM-1:LMEM+1];
            end
        end
    endgenerate

    rr_arbiter #(
        .N (NCORES)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (sh_req),
        .gnt (gnt)
    );

    // Private requests are always taken; shared ones only when granted.
    assign acc            = rst ? '0 : (priv_req | gnt);
    assign bus.core_ready = acc;

    // Route the granted core's index and data to the shared port.
    always_comb begin
        sh_win = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (gnt[k]) begin
                sh_win = WW'(k);
            end
        end
        sh_idx   = idx[sh_win];
        sh_wdata = wdata[sh_win];
        sh_we    = (|gnt) & bus.core_we[sh_win];
    end

    // Shared bank write port.
    always_ff @(posedge clk) begin
        if (sh_we) begin
            sh_mem_q[sh_idx] <= sh_wdata;
        end
    end

    // Per-core private bank and registered read result.
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_core
            logic [TAM-1:0] mem_q [DEPTH];
            logic [TAM-1:0] rdata_q;
            logic           rvalid_q;
            logic           rvalid_d;
            logic           priv_wr;

            // A simultaneous we/re is a write and produces no read.
            assign priv_wr  = acc[gi] & priv_req[gi] & bus.core_we[gi];
            assign rvalid_d = acc[gi] & bus.core_re[gi] & ~bus.core_we[gi];

            // Private bank write port.
            always_ff @(posedge clk) begin
                if (priv_wr) begin
                    mem_q[idx[gi]] <= wdata[gi];
                end
            end

            // Read data loads only on an accepted read and holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rvalid_d;
                    if (rvalid_d) begin
                        rdata_q <= priv_req[gi] ? mem_q[idx[gi]] : sh_mem_q[idx[gi]];
                    end
                end
            end

            assign bus.core_rdata[gi*TAM +: TAM] = rdata_q;
            assign bus.core_rvalid[gi]           = rvalid_q;
        end
    endgenerate

`ifdef DMEM_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;
    logic        denied;

    assign denied = |(sh_req & ~gnt);

    // Saturating count of cycles with at least one refused shared request.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (denied && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
